// File: rtl/gate_vec_stream.sv
// Registered neighbour-gate stream stage: per-beat AND/OR/XOR of adjacent bits,
// temporal toggle against the previous beat, popcount, and a saturating difference total.
module gate_vec_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  localparam int POP_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrap_en,
  input  logic               acc_clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-2:0]   out_both,
  output logic [WIDTH-2:0]   out_any,
  output logic [WIDTH-1:0]   out_diff,
  output logic [WIDTH-1:0]   out_toggle,
  output logic [POP_W-1:0]   out_pop,
  output logic [CNT_W-1:0]   diff_total
);

  // One extra bit lets the sum overflow past CNT_MAX without wrapping before the clamp.
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{(POP_W-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  logic               accept_s;
  logic               xfer_s;
  logic [WIDTH-2:0]   both_s;
  logic [WIDTH-2:0]   any_s;
  logic [WIDTH-1:0]   diff_s;
  logic [POP_W-1:0]   pop_s;
  logic [SUM_W-1:0]   base_s;
  logic [SUM_W-1:0]   sum_s;

  logic               out_valid_q,  out_valid_d;
  logic [WIDTH-2:0]   out_both_q,   out_both_d;
  logic [WIDTH-2:0]   out_any_q,    out_any_d;
  logic [WIDTH-1:0]   out_diff_q,   out_diff_d;
  logic [WIDTH-1:0]   out_toggle_q, out_toggle_d;
  logic [POP_W-1:0]   out_pop_q,    out_pop_d;
  logic [CNT_W-1:0]   diff_total_q, diff_total_d;
  logic [WIDTH-1:0]   prev_q,       prev_d;

  assign in_ready = ~out_valid_q | out_ready;
  assign accept_s = in_valid & in_ready;
  assign xfer_s   = out_valid_q & out_ready;

  // Neighbour gates and popcount of the incoming beat.
  always_comb begin
    both_s = '0;
    any_s  = '0;
    diff_s = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      both_s[i] = in_data[i+1] & in_data[i];
      any_s[i]  = in_data[i+1] | in_data[i];
      diff_s[i] = in_data[i+1] ^ in_data[i];
    end
    if (wrap_en) begin
      diff_s[WIDTH-1] = in_data[0] ^ in_data[WIDTH-1];
    end else begin
      diff_s[WIDTH-1] = 1'b0;
    end
    pop_s = popcount(diff_s);
  end

  // Next-state for output registers, previous vector and the running total.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_both_d   = out_both_q;
    out_any_d    = out_any_q;
    out_diff_d   = out_diff_q;
    out_toggle_d = out_toggle_q;
    out_pop_d    = out_pop_q;
    prev_d       = prev_q;
    diff_total_d = diff_total_q;

    // Clear happens before the add so a same-cycle accept contributes its popcount.
    if (acc_clr) begin
      base_s = '0;
    end else begin
      base_s = SUM_W'(diff_total_q);
    end
    sum_s = base_s + SUM_W'(pop_s);

    if (accept_s) begin
      out_valid_d  = 1'b1;
      out_both_d   = both_s;
      out_any_d    = any_s;
      out_diff_d   = diff_s;
      out_toggle_d = in_data ^ prev_q;
      out_pop_d    = pop_s;
      prev_d       = in_data;
      if (sum_s > CNT_MAX) begin
        diff_total_d = {CNT_W{1'b1}};
      end else begin
        diff_total_d = sum_s[CNT_W-1:0];
      end
    end else begin
      if (xfer_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      diff_total_d = base_s[CNT_W-1:0];
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_both_q   <= '0;
      out_any_q    <= '0;
      out_diff_q   <= '0;
      out_toggle_q <= '0;
      out_pop_q    <= '0;
      prev_q       <= '0;
      diff_total_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_both_q   <= out_both_d;
      out_any_q    <= out_any_d;
      out_diff_q   <= out_diff_d;
      out_toggle_q <= out_toggle_d;
      out_pop_q    <= out_pop_d;
      prev_q       <= prev_d;
      diff_total_q <= diff_total_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_both   = out_both_q;
  assign out_any    = out_any_q;
  assign out_diff   = out_diff_q;
  assign out_toggle = out_toggle_q;
  assign out_pop    = out_pop_q;
  assign diff_total = diff_total_q;

endmodule

// File: tb/tb_gate_vec_stream.sv
// Directed bench for gate_vec_stream: a WIDTH=4 instance for the datapath and
// handshake, and a WIDTH=4/CNT_W=4 instance for accumulator saturation.
module tb_gate_vec_stream;

  logic clk;
  logic rst_n;

  // Main instance (CNT_W=16)
  logic       wrap_en, acc_clr, in_valid, out_ready;
  logic [3:0] in_data;
  logic       in_ready, out_valid;
  logic [2:0] out_both, out_any;
  logic [3:0] out_diff, out_toggle;
  logic [2:0] out_pop;
  logic [15:0] diff_total;

  // Saturation instance (CNT_W=4)
  logic       s_wrap_en, s_acc_clr, s_in_valid, s_out_ready;
  logic [3:0] s_in_data;
  logic       s_in_ready, s_out_valid;
  logic [2:0] s_out_both, s_out_any;
  logic [3:0] s_out_diff, s_out_toggle;
  logic [2:0] s_out_pop;
  logic [3:0] s_diff_total;

  int n_checks = 0;
  int n_fail   = 0;

  gate_vec_stream #(.WIDTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .wrap_en(wrap_en), .acc_clr(acc_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_both(out_both), .out_any(out_any), .out_diff(out_diff),
    .out_toggle(out_toggle), .out_pop(out_pop), .diff_total(diff_total)
  );

  gate_vec_stream #(.WIDTH(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .wrap_en(s_wrap_en), .acc_clr(s_acc_clr),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_both(s_out_both), .out_any(s_out_any), .out_diff(s_out_diff),
    .out_toggle(s_out_toggle), .out_pop(s_out_pop), .diff_total(s_diff_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] alt_v;
  logic [3:0] sat_exp [5];

  initial begin
    rst_n = 1'b0;
    wrap_en = 1'b0; acc_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = 4'b0000;
    s_wrap_en = 1'b1; s_acc_clr = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1; s_in_data = 4'b0000;
    sat_exp[0] = 4'd4; sat_exp[1] = 4'd8; sat_exp[2] = 4'd12; sat_exp[3] = 4'd15; sat_exp[4] = 4'd15;

    // Reset state
    step();
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_diff_total", {48'd0, diff_total}, 64'd0);
    check_eq("rst_out_pop", {61'd0, out_pop}, 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Test 1: 1011 with wrap
    in_valid = 1'b1; in_data = 4'b1011; wrap_en = 1'b1;
    step();
    check_eq("t1_valid", {63'd0, out_valid}, 64'd1);
    check_eq("t1_both", {61'd0, out_both}, 64'b001);
    check_eq("t1_any", {61'd0, out_any}, 64'b111);
    check_eq("t1_diff", {60'd0, out_diff}, 64'b0110);
    check_eq("t1_pop", {61'd0, out_pop}, 64'd2);
    check_eq("t1_toggle", {60'd0, out_toggle}, 64'b1011);
    check_eq("t1_total", {48'd0, diff_total}, 64'd2);

    // Test 2: same vector without wrap, then 0001 with wrap
    wrap_en = 1'b0;
    step();
    check_eq("t2a_diff", {60'd0, out_diff}, 64'b0110);
    check_eq("t2a_toggle", {60'd0, out_toggle}, 64'b0000);
    check_eq("t2a_total", {48'd0, diff_total}, 64'd4);
    in_data = 4'b0001; wrap_en = 1'b1;
    step();
    check_eq("t2b_diff", {60'd0, out_diff}, 64'b1001);
    check_eq("t2b_pop", {61'd0, out_pop}, 64'd2);
    check_eq("t2b_toggle", {60'd0, out_toggle}, 64'b1010);
    check_eq("t2b_total", {48'd0, diff_total}, 64'd6);

    // Test 3: backpressure
    in_data = 4'b0101;
    step();
    check_eq("t3_diff", {60'd0, out_diff}, 64'b1111);
    check_eq("t3_total", {48'd0, diff_total}, 64'd10);
    out_ready = 1'b0; in_data = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("t3_stall_ready", {63'd0, in_ready}, 64'd0);
      step();
      check_eq("t3_stall_valid", {63'd0, out_valid}, 64'd1);
      check_eq("t3_stall_diff", {60'd0, out_diff}, 64'b1111);
      check_eq("t3_stall_toggle", {60'd0, out_toggle}, 64'b0100);
      check_eq("t3_stall_total", {48'd0, diff_total}, 64'd10);
    end
    out_ready = 1'b1;
    #1;
    check_eq("t3_release_ready", {63'd0, in_ready}, 64'd1);
    step();
    check_eq("t3_rel_diff", {60'd0, out_diff}, 64'b0000);
    check_eq("t3_rel_both", {61'd0, out_both}, 64'b111);
    check_eq("t3_rel_toggle", {60'd0, out_toggle}, 64'b1010);
    check_eq("t3_rel_total", {48'd0, diff_total}, 64'd10);

    // Test 4: streaming 8 beats, total cleared on the first beat
    for (int b = 0; b < 8; b++) begin
      alt_v = (b % 2 == 0) ? 4'b1010 : 4'b0101;
      in_data = alt_v;
      acc_clr = (b == 0) ? 1'b1 : 1'b0;
      step();
      check_eq("t4_valid", {63'd0, out_valid}, 64'd1);
      check_eq("t4_pop", {61'd0, out_pop}, 64'd4);
      check_eq("t4_toggle", {60'd0, out_toggle}, (b == 0) ? 64'b0101 : 64'b1111);
    end
    acc_clr = 1'b0;
    check_eq("t4_total", {48'd0, diff_total}, 64'd32);
    in_valid = 1'b0;
    step();
    check_eq("t4_drain_valid", {63'd0, out_valid}, 64'd0);
    check_eq("t4_hold_total", {48'd0, diff_total}, 64'd32);

    // Test 5: saturation on the CNT_W=4 instance
    s_in_valid = 1'b1; s_in_data = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("t5_sat_total", {60'd0, s_diff_total}, {60'd0, sat_exp[k]});
    end
    s_acc_clr = 1'b1; s_in_data = 4'b0011;
    step();
    check_eq("t5_clr_add_pop", {61'd0, s_out_pop}, 64'd2);
    check_eq("t5_clr_add_total", {60'd0, s_diff_total}, 64'd2);
    s_in_valid = 1'b0;
    step();
    check_eq("t5_clr_only_total", {60'd0, s_diff_total}, 64'd0);
    s_acc_clr = 1'b0;

    // Test 6: asynchronous reset mid-stream
    in_valid = 1'b1; in_data = 4'b0110;
    step();
    check_eq("t6_pre_valid", {63'd0, out_valid}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("t6_rst_total", {48'd0, diff_total}, 64'd0);
    check_eq("t6_rst_toggle", {60'd0, out_toggle}, 64'd0);
    step();
    check_eq("t6_held_valid", {63'd0, out_valid}, 64'd0);
    rst_n = 1'b1; in_data = 4'b1000; wrap_en = 1'b1;
    step();
    check_eq("t6_post_valid", {63'd0, out_valid}, 64'd1);
    check_eq("t6_post_toggle", {60'd0, out_toggle}, 64'b1000);
    check_eq("t6_post_diff", {60'd0, out_diff}, 64'b1100);
    check_eq("t6_post_total", {48'd0, diff_total}, 64'd2);
    in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_vec_stream.md
Name: gate_vec_stream

Overview:
- Parametrised, registered successor to the 4-bit neighbour-gate block.
- Accepts a WIDTH-bit vector per beat through a valid/ready handshake.
- Produces registered neighbour AND/OR/XOR vectors, optional wrap-around, a per-beat temporal toggle vector against the previous accepted beat, and the per-beat popcount of neighbour differences.
- Keeps a saturating running total of differing-neighbour bits; sits in streaming datapaths as a bit-pattern/edge pre-processor.

Parameters:
WIDTH, 8, input vector width; legal range 2..64
CNT_W, 16, width of running difference accumulator
POP_W, $clog2(WIDTH+1), popcount width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
wrap_en  input  1  1: out_diff[WIDTH-1] = in[0]^in[WIDTH-1]; 0: that bit forced 0; sampled on accepted beat
acc_clr  input  1  synchronous clear of diff_total
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  input vector
out_valid  output  1  output registers hold a beat
out_ready  input  1  downstream accepts
out_both  output  WIDTH-1  bit i = in[i+1] & in[i]
out_any  output  WIDTH-1  bit i = in[i+1] | in[i]
out_diff  output  WIDTH  bit i = in[i+1] ^ in[i] for i<WIDTH-1; bit WIDTH-1 per wrap_en
out_toggle  output  WIDTH  in_data ^ previously accepted in_data
out_pop  output  POP_W  number of ones in out_diff
diff_total  output  CNT_W  saturating sum of out_pop over all accepted beats

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_both/out_any/out_diff/out_toggle/out_pop=0, diff_total=0, prev vector=0. in_ready comes out of reset as 1.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational; one output register, no skid buffer).
  - Accept when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_data and wrap_en need only be stable in the accept cycle.
- Latency: an accepted beat appears on the outputs with out_valid=1 on the next clock edge, i.e. one cycle.
- On accept:
  - Load all out_* from in_data and wrap_en.
  - prev vector <= in_data.
  - out_valid <= 1.
- On transfer without accept: out_valid <= 0. Data registers hold their last value (don't care while out_valid=0; they are not cleared).
- Simultaneous transfer and accept: out_valid stays 1, registers load the new beat. This gives full throughput of one beat per cycle.
- Stall (out_valid=1, out_ready=0): in_ready=0 and all outputs hold stable. in_valid high is ignored.
- Temporal toggle: the first accepted beat after reset compares against 0, so out_toggle equals in_data.
- Popcount is computed on the same cycle's out_diff value, including the wrap bit when enabled.
- diff_total:
  - Updates on accept cycles (not transfer): diff_total <= min(diff_total + pop_new, 2^CNT_W-1). Saturation holds; it never wraps.
  - acc_clr=1: diff_total <= 0. If acc_clr and accept happen in the same cycle, the result is diff_total <= pop_new (clear, then add).
- Reset mid-operation: an in-flight beat is dropped, prev vector returns to 0, and no partial output remains.
- WIDTH=2: out_both/out_any are 1 bit. With wrap_en=1, out_diff[1] = in[0]^in[1], which duplicates bit 0.

Test Plan:
1. WIDTH=4, wrap_en=1, out_ready=1, accept in_data=4'b1011.
   - Next cycle: out_both=3'b001, out_any=3'b111, out_diff=4'b0110, out_pop=2, out_toggle=4'b1011, diff_total=2.
2. Same vector with wrap_en=0:
   - out_diff=4'b0110 (wrap bit 0). Then in_data=4'b0001, wrap_en=1: out_diff=4'b1001, out_pop=2, out_toggle=4'b1010.
3. Backpressure: accept 4'b0101, then hold out_ready=0 for 3 cycles with in_valid=1 and in_data=4'b1111.
   - in_ready=0 throughout; outputs stay 4'b0101 results.
   - Release: 4'b1111 is accepted in the release cycle and appears next cycle.
4. Streaming: 8 back-to-back beats alternating 4'b1010/4'b0101 with out_ready=1, wrap_en=1.
   - One output per cycle, each out_pop=4, out_toggle=4'b1111 after the first beat.
   - diff_total=32, no bubbles.
5. Saturation: CNT_W=4, feed 4'b1010 (pop 4) with wrap_en=1 five times.
   - diff_total goes 4, 8, 12, 15, 15.
   - acc_clr with a concurrent accept of 4'b0011 (pop 2) gives diff_total=2.
6. Async reset: assert rst_n=0 mid-stream, between clock edges.
   - out_valid and diff_total drop to 0 immediately.
   - After release, the first beat 4'b1000 gives out_toggle=4'b1000.
